// File: rtl/demux_1_4_stream.sv
// rtl/demux_1_4_stream.sv - 1-to-4 valid/ready stream demultiplexer with per-channel holding registers
//
// Purpose:
//   Routes each accepted input word to one of four output channels selected
//   by in_sel. Every channel owns a single-entry register, so a stalled
//   consumer only blocks input words that are addressed to its channel.
//   A word accepted at one edge is visible on its channel after that edge.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - asynchronous active-high reset, clears all buffered words
//   in_valid   - input word present
//   in_ready   - input word can be taken this cycle
//   in_data    - input word (W bits)
//   in_sel     - destination channel 0..3
//   out_valid  - bit k: channel k holds a word
//   out_ready  - bit k: consumer of channel k takes the word this cycle
//   out_data   - channel k word on bits [k*W +: W]
//   xfer_cnt   - accepted input transfer count, wraps modulo 2^CNT_W

module demux_1_4_stream #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [4*W-1:0]   out_data,
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [3:0]       r_valid;
  logic [4*W-1:0]   r_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_load;

  // The addressed slot is free if empty or being drained this same cycle,
  // which gives back-to-back throughput per channel without a bubble.
  assign w_in_ready = !rst && (!r_valid[in_sel] || out_ready[in_sel]);
  assign w_accept   = in_valid && w_in_ready;

  // Load strobes are gated by w_accept, so in_sel is ignored when idle.
  always_comb begin
    w_load = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      w_load[k] = w_accept && (in_sel == 2'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 4'b0000;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_valid[k]         <= 1'b1;
          r_data[k*W +: W]   <= in_data;
        end else if (r_valid[k] && out_ready[k]) begin
          // Data is left as-is; it is don't-care once the slot is invalid.
          r_valid[k]         <= 1'b0;
        end
      end
      if (w_accept) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign xfer_cnt  = r_cnt;

endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb/tb_demux_1_4_stream.sv - self-checking bench for demux_1_4_stream

module tb_demux_1_4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [15:0] out_data;
  logic [7:0]  xfer_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  demux_1_4_stream #(.W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_cnt  (xfer_cnt)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [3:0]  d;
    logic [3:0]  ordy;
    logic        e_rdy;
    logic [3:0]  e_ov;
    logic [15:0] e_od;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t tbl [14];

  // reference model: one FIFO per channel plus a plain transfer count
  logic [3:0] mq [4][$];
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] vmask(input logic [3:0] ov);
    logic [15:0] m;
    m = 16'h0;
    for (int k = 0; k < 4; k++) if (ov[k]) m[k*4 +: 4] = 4'hf;
    return m;
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0]  r_ov;
    logic [15:0] r_od;
    logic        e_rdy;
    logic [15:0] e_od;
    logic [3:0]  e_ov;
    logic [1:0]  h_sel;
    logic [3:0]  h_data;
    logic        h_hold;

    //              v  sel d     ordy     rdy ov       od        cnt
    tbl[0]  = '{1'b1, 2'd0, 4'ha, 4'b1111, 1'b1, 4'b0000, 16'h0000, 8'd0};
    tbl[1]  = '{1'b1, 2'd1, 4'hb, 4'b1111, 1'b1, 4'b0001, 16'h000a, 8'd1};
    tbl[2]  = '{1'b1, 2'd2, 4'hc, 4'b1111, 1'b1, 4'b0010, 16'h00b0, 8'd2};
    tbl[3]  = '{1'b1, 2'd3, 4'hd, 4'b1111, 1'b1, 4'b0100, 16'h0c00, 8'd3};
    tbl[4]  = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b1000, 16'hd000, 8'd4};
    tbl[5]  = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h0000, 8'd4};
    tbl[6]  = '{1'b1, 2'd2, 4'h7, 4'b1011, 1'b1, 4'b0000, 16'h0000, 8'd4};
    tbl[7]  = '{1'b1, 2'd1, 4'h5, 4'b1011, 1'b1, 4'b0100, 16'h0700, 8'd5};
    tbl[8]  = '{1'b1, 2'd2, 4'h3, 4'b1011, 1'b0, 4'b0110, 16'h0750, 8'd6};
    tbl[9]  = '{1'b1, 2'd2, 4'h3, 4'b1011, 1'b0, 4'b0100, 16'h0700, 8'd6};
    tbl[10] = '{1'b1, 2'd2, 4'h3, 4'b1111, 1'b1, 4'b0100, 16'h0700, 8'd6};
    tbl[11] = '{1'b0, 2'd0, 4'h0, 4'b1011, 1'b1, 4'b0100, 16'h0300, 8'd7};
    tbl[12] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0100, 16'h0300, 8'd7};
    tbl[13] = '{1'b0, 2'd0, 4'h0, 4'b1111, 1'b1, 4'b0000, 16'h0000, 8'd7};

    rst = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 4'h0);
    #2;
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    chk("reset_xfer_cnt", 32'(xfer_cnt), 32'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // routing and backpressure vectors
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_data", i), 32'(out_data & vmask(tbl[i].e_ov)),
          32'(tbl[i].e_od & vmask(tbl[i].e_ov)));
      chk($sformatf("tbl%0d_xfer_cnt", i), 32'(xfer_cnt), 32'(tbl[i].e_cnt));
      next_cycle();
    end

    // asynchronous reset mid-cycle with channels 0 and 2 occupied
    drive(1'b1, 2'd0, 4'h9, 4'b0000);
    next_cycle();
    drive(1'b1, 2'd2, 4'h6, 4'b0000);
    next_cycle();
    drive(1'b0, 2'd2, 4'h0, 4'b0000);
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(out_valid), 32'h5);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_out_data", 32'(out_data), 32'h0);
    chk("async_rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h0);
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("idle_in_ready", 32'(in_ready), 32'h1);
      chk("idle_out_valid", 32'(out_valid), 32'h0);
      chk("idle_xfer_cnt", 32'(xfer_cnt), 32'h0);
      next_cycle();
    end

    // back-to-back words 0..7 into channel 0 while it drains
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 2'd0, 4'(i), 4'b1111);
      @(negedge clk);
      chk("burst_in_ready", 32'(in_ready), 32'h1);
      if (i > 0) begin
        chk("burst_valid0", 32'(out_valid[0]), 32'h1);
        chk("burst_data0", 32'(out_data[3:0]), 32'(i - 1));
      end
      next_cycle();
    end
    drive(1'b0, 2'd0, 4'h0, 4'b1111);
    @(negedge clk);
    chk("burst_last_valid", 32'(out_valid), 32'h1);
    chk("burst_last_data", 32'(out_data[3:0]), 32'h7);
    chk("burst_cnt", 32'(xfer_cnt), 32'd8);

    // counter wrap over 257 accepts
    do_reset();
    for (int i = 0; i <= 257; i++) begin
      drive(i < 257, 2'(i % 4), 4'(i), 4'b1111);
      @(negedge clk);
      if (i >= 255) chk($sformatf("wrap_cnt_after_%0d", i), 32'(xfer_cnt), 32'(i % 256));
      next_cycle();
    end

    // idle input with unknown select/data must not disturb held state
    drive(1'b1, 2'd1, 4'h5, 4'b0000);
    next_cycle();
    in_valid  = 1'b0;
    in_sel    = 2'bxx;
    in_data   = 4'bxxxx;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("xidle_out_valid", 32'(out_valid), 32'h2);
      chk("xidle_data1", 32'(out_data[7:4]), 32'h5);
      chk("xidle_cnt", 32'(xfer_cnt), 32'd2);
      chk("xidle_known", 32'($isunknown({out_valid, out_data, xfer_cnt})), 32'h0);
      next_cycle();
    end

    // random traffic against the queue model
    do_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    m_cnt  = 0;
    h_hold = 1'b0;
    h_sel  = 2'd0;
    h_data = 4'h0;
    for (int c = 0; c < 600; c++) begin
      if (h_hold) begin
        drive(1'b1, h_sel, h_data, 4'($urandom_range(0, 15)));
      end else begin
        drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      @(negedge clk);
      e_ov = 4'b0000;
      e_od = 16'h0;
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0) begin
          e_ov[k] = 1'b1;
          e_od[k*4 +: 4] = mq[k][0];
        end
      end
      e_rdy = (mq[in_sel].size() == 0) || out_ready[in_sel];
      r_ov = out_valid;
      r_od = out_data & vmask(e_ov);
      chk("rand_out_valid", 32'(r_ov), 32'(e_ov));
      chk("rand_out_data", 32'(r_od), 32'(e_od));
      chk("rand_in_ready", 32'(in_ready), 32'(e_rdy));
      chk("rand_xfer_cnt", 32'(xfer_cnt), 32'(m_cnt % 256));
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && out_ready[k]) void'(mq[k].pop_front());
      end
      if (in_valid && e_rdy) begin
        mq[in_sel].push_back(in_data);
        m_cnt++;
      end
      h_hold = in_valid && !e_rdy;
      h_sel  = in_sel;
      h_data = in_data;
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
